// File: rtl/cache_refill_controller.sv
// Miss sequencer for the set-associative cache: picks a victim, writes it back if dirty,
// bursts the new line in word by word, then commits tag/valid/dirty for that way.
module cache_refill_controller #(
  parameter int CACHE_LINES     = 256,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int TAG_BITS        = 18,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WAYS            = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           i_miss_req,
  input  logic [TAG_BITS-1:0]                            i_tag,
  input  logic [$clog2(CACHE_LINES)-1:0]                 i_index,
  input  logic [WAYS-1:0]                                i_valid,
  input  logic [WAYS-1:0]                                i_dirty,
  input  logic [$clog2(WAYS)-1:0]                        i_lru_way,
  input  logic [WAYS*TAG_BITS-1:0]                       i_way_tags,
  output logic [$clog2(WAYS)-1:0]                        o_arr_way,
  output logic [$clog2(CACHE_LINES)-1:0]                 o_arr_index,
  output logic [$clog2(LINE_SIZE_BYTES*8/DATA_WIDTH)-1:0] o_arr_word,
  input  logic [DATA_WIDTH-1:0]                          i_arr_rdata,
  output logic                                           o_fill_we,
  output logic [DATA_WIDTH-1:0]                          o_fill_data,
  output logic                                           o_tag_we,
  output logic [TAG_BITS-1:0]                            o_tag,
  output logic                                           o_mem_req,
  output logic                                           o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]                       o_mem_addr,
  input  logic                                           i_mem_ack,
  output logic                                           o_mem_wvalid,
  output logic [DATA_WIDTH-1:0]                          o_mem_wdata,
  input  logic                                           i_mem_wready,
  input  logic                                           i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                          i_mem_rdata,
  output logic                                           o_busy,
  output logic                                           o_done
);

  localparam int INDEX_BITS  = $clog2(CACHE_LINES);
  localparam int OFFSET_BITS = $clog2(LINE_SIZE_BYTES);
  localparam int BEATS       = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
  localparam int WORD_BITS   = $clog2(BEATS);
  localparam int WAY_BITS    = $clog2(WAYS);
  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, UPDATE, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_BITS-1:0]   cnt_q, cnt_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [TAG_BITS-1:0]    vtag_q, vtag_d;
  logic [INDEX_BITS-1:0]  index_q, index_d;
  logic [WAY_BITS-1:0]    way_q, way_d;

  logic [WAY_BITS-1:0]    victim;
  logic                   victim_found;
  logic [TAG_BITS-1:0]    victim_tag;
  logic                   victim_wb;

  // An empty way always beats the LRU choice so valid lines are not evicted needlessly.
  always_comb begin
    victim       = i_lru_way;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !i_valid[w]) begin
        victim       = WAY_BITS'(w);
        victim_found = 1'b1;
      end
    end
    victim_tag = i_way_tags[victim*TAG_BITS +: TAG_BITS];
    victim_wb  = i_valid[victim] & i_dirty[victim];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      index_q <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      vtag_q  <= vtag_d;
      index_q <= index_d;
      way_q   <= way_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tag_d        = tag_q;
    vtag_d       = vtag_q;
    index_d      = index_q;
    way_d        = way_q;
    o_arr_way    = way_q;
    o_arr_index  = index_q;
    o_arr_word   = cnt_q;
    o_fill_we    = 1'b0;
    o_fill_data  = '0;
    o_tag_we     = 1'b0;
    o_tag        = '0;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wvalid = 1'b0;
    o_mem_wdata  = '0;
    o_busy       = (state_q != IDLE) && (state_q != DONE);
    o_done       = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (i_miss_req) begin
          tag_d   = i_tag;
          index_d = i_index;
          way_d   = victim;
          vtag_d  = victim_tag;
          state_d = victim_wb ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b1;
        o_mem_addr = {vtag_q, index_q, {OFFSET_BITS{1'b0}}};
        if (i_mem_ack) begin
          cnt_d   = '0;
          state_d = WB_DATA;
        end
      end
      WB_DATA: begin
        // Word select only moves on acceptance, so a stalled beat keeps its data.
        o_mem_wvalid = 1'b1;
        o_mem_wdata  = i_arr_rdata;
        if (i_mem_wready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {tag_q, index_q, {OFFSET_BITS{1'b0}}};
        if (i_mem_ack) begin
          cnt_d   = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (i_mem_rvalid) begin
          o_fill_we   = 1'b1;
          o_fill_data = i_mem_rdata;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = UPDATE;
        end
      end
      UPDATE: begin
        o_tag_we = 1'b1;
        o_tag    = tag_q;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_controller.sv
// Scoreboarded bench for cache_refill_controller: directed misses, memory responder with
// optional backpressure, and a negedge monitor that pops expected events as they appear.
module tb_cache_refill_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss_req = 1'b0;
  logic [17:0] i_tag = '0;
  logic [7:0]  i_index = '0;
  logic [3:0]  i_valid = '0;
  logic [3:0]  i_dirty = '0;
  logic [1:0]  i_lru_way = '0;
  logic [71:0] i_way_tags = '0;
  logic [1:0]  o_arr_way;
  logic [7:0]  o_arr_index;
  logic [3:0]  o_arr_word;
  logic [31:0] i_arr_rdata;
  logic        o_fill_we;
  logic [31:0] o_fill_data;
  logic        o_tag_we;
  logic [17:0] o_tag;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic        o_mem_wvalid;
  logic [31:0] o_mem_wdata;
  logic        i_mem_wready = 1'b1;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_busy;
  logic        o_done;

  cache_refill_controller dut (
    .clk(clk), .rst(rst), .i_miss_req(i_miss_req), .i_tag(i_tag), .i_index(i_index),
    .i_valid(i_valid), .i_dirty(i_dirty), .i_lru_way(i_lru_way), .i_way_tags(i_way_tags),
    .o_arr_way(o_arr_way), .o_arr_index(o_arr_index), .o_arr_word(o_arr_word),
    .i_arr_rdata(i_arr_rdata), .o_fill_we(o_fill_we), .o_fill_data(o_fill_data),
    .o_tag_we(o_tag_we), .o_tag(o_tag), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack), .o_mem_wvalid(o_mem_wvalid),
    .o_mem_wdata(o_mem_wdata), .i_mem_wready(i_mem_wready), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  way;
    logic [7:0]  idx;
    logic [3:0]  word;
    logic [31:0] dat;
  } beat_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } req_t;

  typedef struct packed {
    logic [1:0]  way;
    logic [7:0]  idx;
    logic [17:0] tag;
  } tagc_t;

  beat_t       q_wb[$];
  beat_t       q_fill[$];
  req_t        q_req[$];
  tagc_t       q_tag[$];
  int          q_lat[$];
  logic [31:0] q_rbase[$];

  int total = 0;
  int bad   = 0;
  int fill_seen = 0;
  int busy_run  = 0;
  bit bp   = 1'b0;
  int rgap = 0;

  function automatic logic [31:0] arr_fn(input logic [1:0] w, input logic [7:0] idx,
                                         input logic [3:0] wd);
    return {4'hA, 2'b00, w, idx, 8'h5C, 4'h0, wd};
  endfunction

  assign i_arr_rdata = arr_fn(o_arr_way, o_arr_index, o_arr_word);
  assign i_mem_ack   = o_mem_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  task automatic push_miss(input logic [17:0] tag, input logic [7:0] idx, input logic [1:0] way,
                           input bit wb, input logic [17:0] vtag, input logic [31:0] rbase,
                           input int lat);
    beat_t b;
    if (wb) begin
      q_req.push_back({1'b1, vtag, idx, 6'b0});
      for (int k = 0; k < 16; k++) begin
        b = '{way: way, idx: idx, word: 4'(k), dat: arr_fn(way, idx, 4'(k))};
        q_wb.push_back(b);
      end
    end
    q_req.push_back({1'b0, tag, idx, 6'b0});
    for (int k = 0; k < 16; k++) begin
      b = '{way: way, idx: idx, word: 4'(k), dat: rbase + 32'(k)};
      q_fill.push_back(b);
    end
    q_tag.push_back('{way: way, idx: idx, tag: tag});
    q_lat.push_back(lat);
    q_rbase.push_back(rbase);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    if (!seen) unexpected(name);
  endtask

  task automatic run_miss(input logic [17:0] tag, input logic [7:0] idx, input logic [3:0] valid,
                          input logic [3:0] dirty, input logic [1:0] lru, input logic [71:0] wtags);
    @(posedge clk); #1;
    i_tag = tag; i_index = idx; i_valid = valid; i_dirty = dirty;
    i_lru_way = lru; i_way_tags = wtags; i_miss_req = 1'b1;
    wait_done("done_timeout");
    @(posedge clk); #1;
    i_miss_req = 1'b0;
  endtask

  // Monitor: every DUT-presented event must match the head of its queue.
  logic        stall_prev = 1'b0;
  logic [35:0] held = '0;
  always @(negedge clk) begin
    if (rst) begin
      busy_run   = 0;
      stall_prev = 1'b0;
    end else begin
      if (o_mem_req && i_mem_ack) begin
        if (q_req.size() == 0) unexpected("mem_req");
        else chk("mem_req", {o_mem_we, o_mem_addr}, q_req.pop_front());
      end
      if (stall_prev && o_mem_wvalid) chk("wb_hold", {o_arr_word, o_mem_wdata}, held);
      stall_prev = o_mem_wvalid && !i_mem_wready;
      held       = {o_arr_word, o_mem_wdata};
      if (o_mem_wvalid && i_mem_wready) begin
        if (q_wb.size() == 0) unexpected("wb_beat");
        else chk("wb_beat", {o_arr_way, o_arr_index, o_arr_word, o_mem_wdata}, q_wb.pop_front());
      end
      if (o_fill_we) begin
        fill_seen++;
        if (q_fill.size() == 0) unexpected("fill");
        else chk("fill", {o_arr_way, o_arr_index, o_arr_word, o_fill_data}, q_fill.pop_front());
      end
      if (o_tag_we) begin
        if (q_tag.size() == 0) unexpected("tag_we");
        else chk("tag_we", {o_arr_way, o_arr_index, o_tag}, q_tag.pop_front());
      end
      if (o_busy) busy_run++;
      if (o_done) begin
        if (q_lat.size() == 0) unexpected("done");
        else begin
          int lat;
          lat = q_lat.pop_front();
          if (lat != 0) chk("latency", 64'(busy_run + 1), 64'(lat));
        end
        busy_run = 0;
      end
    end
  end

  // Memory read responder: after each read-request accept, deliver 16 beats with rgap idles each.
  initial begin
    logic [31:0] rb;
    forever begin
      @(negedge clk);
      if (!rst && o_mem_req && i_mem_ack && !o_mem_we) begin
        rb = (q_rbase.size() != 0) ? q_rbase.pop_front() : 32'h0;
        @(posedge clk); #1;
        for (int k = 0; k < 16 && !rst; k++) begin
          for (int g = 0; g < rgap && !rst; g++) begin
            i_mem_rvalid = 1'b0;
            @(posedge clk); #1;
          end
          if (!rst) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rb + 32'(k);
            @(posedge clk); #1;
          end
        end
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      i_mem_wready = bp ? ~i_mem_wready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    @(negedge clk);
    chk("reset_outputs", 64'({o_arr_way, o_arr_index, o_arr_word, o_fill_we, o_tag_we,
        o_mem_req, o_mem_we, o_mem_wvalid, o_busy, o_done} != 0 ||
        (|{o_fill_data, o_tag, o_mem_addr, o_mem_wdata})), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Clean miss into the first empty way.
    push_miss(18'h2A5A5, 8'h3C, 2'd2, 1'b0, 18'h0, 32'h1000_0000, 19);
    run_miss(18'h2A5A5, 8'h3C, 4'b1011, 4'b0000, 2'd0, {18'h3, 18'h2, 18'h1, 18'h0});

    // Dirty LRU victim: write-back then refill.
    push_miss(18'h0BEEF, 8'h55, 2'd2, 1'b1, 18'h11111, 32'h2000_0000, 36);
    run_miss(18'h0BEEF, 8'h55, 4'b1111, 4'b0100, 2'd2, {18'h33333, 18'h11111, 18'h22222, 18'h00007});

    // Backpressure on both bursts.
    bp = 1'b1; rgap = 3;
    push_miss(18'h12345, 8'h81, 2'd3, 1'b1, 18'h3C3C3, 32'h3000_0000, 0);
    run_miss(18'h12345, 8'h81, 4'b1111, 4'b1000, 2'd3, {18'h3C3C3, 18'h0AAAA, 18'h05555, 18'h00001});
    bp = 1'b0; rgap = 0;

    // Invalid-but-dirty way 0 is chosen with no write-back.
    push_miss(18'h01F0F, 8'h07, 2'd0, 1'b0, 18'h0, 32'h4000_0000, 19);
    run_miss(18'h01F0F, 8'h07, 4'b1110, 4'b0001, 2'd3, {18'h1, 18'h2, 18'h3, 18'h3FFFF});

    // Request held through DONE with set inputs changed mid-miss.
    push_miss(18'h00ABC, 8'h10, 2'd0, 1'b0, 18'h0, 32'h5000_0000, 19);
    push_miss(18'h00DEF, 8'h22, 2'd0, 1'b0, 18'h0, 32'h6000_0000, 19);
    @(posedge clk); #1;
    i_tag = 18'h00ABC; i_index = 8'h10; i_valid = 4'b0000; i_dirty = 4'b0000;
    i_lru_way = 2'd1; i_miss_req = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    i_tag = 18'h00DEF; i_index = 8'h22;
    wait_done("held_done_a");
    @(negedge clk);
    chk("idle_after_done", {62'b0, o_busy, o_done}, 64'd0);
    @(negedge clk);
    chk("reaccept", {63'b0, o_busy}, 64'd1);
    wait_done("held_done_b");
    @(posedge clk); #1;
    i_miss_req = 1'b0;

    // Reset during read beat 5: abort, no tag commit, then a normal miss.
    push_miss(18'h15555, 8'hC3, 2'd3, 1'b0, 18'h0, 32'h7000_0000, 19);
    base = fill_seen;
    @(posedge clk); #1;
    i_tag = 18'h15555; i_index = 8'hC3; i_valid = 4'b0111; i_dirty = 4'b0000;
    i_lru_way = 2'd0; i_miss_req = 1'b1;
    for (int i = 0; i < 200 && fill_seen < base + 5; i++) begin
      @(negedge clk); #1;
    end
    chk("beats_before_reset", 64'(fill_seen - base), 64'd5);
    @(posedge clk); #2;
    rst = 1'b1;
    i_miss_req = 1'b0;
    q_wb.delete(); q_fill.delete(); q_req.delete(); q_tag.delete(); q_lat.delete(); q_rbase.delete();
    @(negedge clk);
    chk("abort_outputs", 64'({o_arr_way, o_arr_index, o_arr_word, o_fill_we, o_tag_we,
        o_mem_req, o_mem_we, o_mem_wvalid, o_busy, o_done} != 0 ||
        (|{o_fill_data, o_tag, o_mem_addr, o_mem_wdata})), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    push_miss(18'h2A5A5, 8'h3C, 2'd1, 1'b0, 18'h0, 32'h8000_0000, 19);
    run_miss(18'h2A5A5, 8'h3C, 4'b1101, 4'b0000, 2'd0, {18'h3, 18'h2, 18'h1, 18'h0});

    repeat (4) @(negedge clk);
    chk("queues_empty", 64'(q_wb.size() + q_fill.size() + q_req.size() + q_tag.size() + q_lat.size()),
        64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_refill_controller.md
Name: cache_refill_controller

Overview:
- Miss-handling sequencer for the 4-way set-associative cache.
- On a lookup miss it picks a victim way, writes the victim back to memory if it is dirty, and bursts the new line in from memory.
- It fills the data array word-by-word, then commits the tag, valid and dirty bits.
- Sits between the cache lookup/array logic and the external memory port; it is the only block that writes the cache arrays on a miss.

Parameters:
- CACHE_LINES, 256, sets per way.
- LINE_SIZE_BYTES, 64, bytes per line.
- TAG_BITS, 18, tag width.
- DATA_WIDTH, 32, memory and array word width. BEATS = LINE_SIZE_BYTES*8/DATA_WIDTH = 16.
- ADDRESS_WIDTH, 32. Must equal TAG_BITS + log2(CACHE_LINES) + log2(LINE_SIZE_BYTES).
- WAYS, 4, associativity; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_miss_req  in  1  miss request; level, held until o_done.
- i_tag  in  TAG_BITS  missing tag.
- i_index  in  log2(CACHE_LINES)  missing set.
- i_valid  in  WAYS  valid bits of set i_index.
- i_dirty  in  WAYS  dirty bits of set i_index.
- i_lru_way  in  log2(WAYS)  LRU way of set i_index.
- i_way_tags  in  WAYS*TAG_BITS  tags of set i_index; way 0 in LSBs.
- o_arr_way  out  log2(WAYS)  victim way to array.
- o_arr_index  out  log2(CACHE_LINES)  latched set.
- o_arr_word  out  log2(BEATS)  word select.
- i_arr_rdata  in  DATA_WIDTH  array word; combinational read of way/index/word.
- o_fill_we  out  1  write o_fill_data into array word.
- o_fill_data  out  DATA_WIDTH  refill word.
- o_tag_we  out  1  commit tag; valid=1, dirty=0.
- o_tag  out  TAG_BITS  tag to commit.
- o_mem_req  out  1  memory burst request.
- o_mem_we  out  1  1 = write burst, 0 = read burst.
- o_mem_addr  out  ADDRESS_WIDTH  line-aligned byte address.
- i_mem_ack  in  1  request accepted.
- o_mem_wvalid  out  1  write beat valid.
- o_mem_wdata  out  DATA_WIDTH  write beat.
- i_mem_wready  in  1  write beat accepted.
- i_mem_rvalid  in  1  read beat valid.
- i_mem_rdata  in  DATA_WIDTH  read beat.
- o_busy  out  1  miss in progress.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter 0; latched tag/index/way 0.
- Reset mid-operation aborts immediately. Nothing further is written, and o_tag_we is never issued for an aborted miss.
- IDLE: when i_miss_req=1 and o_done=0, latch i_tag, i_index and the victim way.
  - Victim = lowest-numbered way with i_valid=0; else i_lru_way.
  - Latch victim dirty and victim tag.
  - o_busy=1 from the next cycle.
  - Go to WB_REQ if victim valid and dirty, else RD_REQ.
- WB_REQ:
  - o_mem_req=1, o_mem_we=1.
  - o_mem_addr = {victim_tag, index, 0}.
  - Hold until i_mem_ack, then go to WB_DATA with counter 0.
- WB_DATA:
  - o_arr_word = counter; o_mem_wvalid=1; o_mem_wdata = i_arr_rdata.
  - Counter increments on each wvalid&wready.
  - A stalled beat holds wdata stable.
  - After beat BEATS-1 is accepted, go to RD_REQ.
- RD_REQ:
  - o_mem_req=1, o_mem_we=0.
  - o_mem_addr = {latched tag, index, 0}.
  - Hold until i_mem_ack, then go to RD_DATA with counter 0.
- RD_DATA:
  - Each cycle with i_mem_rvalid: o_fill_we=1, o_fill_data = i_mem_rdata, o_arr_word = counter (combinational from counter); counter increments.
  - Gaps in rvalid are allowed.
  - Last beat (counter = BEATS-1) goes to UPDATE.
- UPDATE: one cycle; o_tag_we=1, o_tag = latched tag, go to DONE.
- DONE: one cycle; o_done=1, o_busy=0, go to IDLE.
  - A request still high in the DONE cycle is not re-accepted; acceptance requires o_done=0.
- Request hold and mid-miss changes: i_miss_req and the set inputs are ignored outside IDLE.
  - Latched values drive o_arr_index and o_arr_way for the whole miss.
- Counter width and addressing:
  - Counter is log2(BEATS) bits and wraps only at state exit.
  - Memory receives line-aligned addresses only; beat ordering is 0..BEATS-1 ascending.
- Simultaneous events:
  - i_mem_ack in the same cycle the request first asserts is legal; the next state starts the next cycle.
  - i_mem_rvalid outside RD_DATA is ignored.
- Latency, clean miss with zero-wait memory: accept, RD_REQ 1, RD_DATA 16, UPDATE 1, DONE 1.
  - o_done arrives 19 cycles after the accept edge.
  - A dirty miss adds 1 + 16 cycles.

Test Plan:
- Reset during RD_DATA beat 5 -> all outputs 0 next cycle; no o_tag_we; next miss runs normally.
- Clean miss; i_valid=4'b1011, tag 0x2A5A5, index 0x3C, zero-wait memory:
  - victim way 2; read address {0x2A5A5,0x3C,6'b0}; no write burst;
  - 16 o_fill_we pulses with words 0..15 in order; o_tag_we with 0x2A5A5; o_done 19 cycles after accept.
- Dirty miss; all valid, i_dirty=4'b0100, i_lru_way=2, way-2 tag 0x11111:
  - write burst to {0x11111,index,0} with 16 beats equal to array words 0..15;
  - then read burst; done 36 cycles after accept.
- Backpressure: i_mem_wready toggling 1-0-1 and i_mem_rvalid with 3-cycle gaps -> wdata held while stalled; exactly 16 beats each way; no skipped or duplicated o_arr_word.
- i_miss_req held high through DONE, and i_index changed mid-miss -> a single miss only; o_arr_index is constant; a new miss is accepted on the cycle after DONE.
- Clean miss with an invalid-but-dirty way 0 (i_valid=4'b1110, i_dirty=4'b0001) -> victim way 0; no write-back.
